nibble_serial_subtractor: RTL

//  Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, computed one 4-bit

---
 rtl/nibble_serial_subtractor_if.sv | 26 ++
 rtl/nibble_serial_subtractor.sv | 104 ++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The slave modport is the subtractor side; the master modport is the producer/consumer side.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, overflow
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, overflow
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: diff = a - b - bin, one 4-bit CLA nibble per clock.
// Subtraction is done as a + ~b + ~bin; the inter-nibble carry is the inverted borrow.
module nss_cla4 (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       c0_i,
  output logic [3:0] s_o,
  output logic       c4_o
);
  logic [3:0] g, p;
  logic       c1, c2, c3;

  assign g  = x_i & y_i;
  assign p  = x_i ^ y_i;
  assign c1 = g[0] | (p[0] & c0_i);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
  assign c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0_i);
  assign s_o = p ^ {c3, c2, c1, c0_i};
endmodule

module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  nibble_serial_subtractor_if.slave    bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [NIB-1:0][3:0]    a_q, a_d;
  logic [NIB-1:0][3:0]    nb_q, nb_d;
  logic [NIB-1:0][3:0]    diff_q, diff_d;

  logic [3:0]             nib_s;
  logic                   nib_c4;

  nss_cla4 u_cla (
    .x_i  (a_q[idx_q]),
    .y_i  (nb_q[idx_q]),
    .c0_i (carry_q),
    .s_o  (nib_s),
    .c4_o (nib_c4)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    nb_d    = nb_q;
    diff_d  = diff_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a;
        nb_d    = ~bus.b;
        carry_d = ~bus.bin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        diff_d[idx_q] = nib_s;
        carry_d       = nib_c4;
        idx_d         = IW'(idx_q + 1'b1);
        if (idx_q == IW'(NIB - 1)) state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      diff_q  <= diff_d;
    end
  end

  // nb_q holds ~b, so "a and b signs differ" is a sign equal to nb sign.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = (state_q == DONE) & ~carry_q;
  assign bus.overflow  = (state_q == DONE) & (a_q[NIB-1][3] == nb_q[NIB-1][3])
                         & (diff_q[NIB-1][3] != a_q[NIB-1][3]);
endmodule
